branch_resolver: RTL and testbench

Execute-side producer of branch feedback for the fetch unit. It queues each prediction issued at decode in order and checks it against the actual outcome at execute. It emits a registered branch result record for predictor/BTB training and a load-pc redirect on misprediction. It also flushes wrong-path predictions still in flight and counts mispredictions.

---
 rtl/branch_resolver.sv | 144 ++++++++++++++
 tb/tb_branch_resolver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// Execute-side branch resolver: queues decode-time predictions in order and
// checks them against execute outcomes, producing training records and redirects.
module branch_resolver #(
  parameter int ADDR_W = 26,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              dec_valid,
  input  logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_prediction,
  input  logic              dec_is_jump,
  input  logic [ADDR_W-1:0] dec_target,
  input  logic              ex_valid,
  input  logic              ex_outcome,
  input  logic [ADDR_W-1:0] ex_target,
  output logic              full,
  output logic              o_res_valid,
  output logic [ADDR_W-1:0] o_res_pc,
  output logic [ADDR_W-1:0] o_res_target,
  output logic              o_res_prediction,
  output logic              o_res_outcome,
  output logic              o_load_we,
  output logic [ADDR_W-1:0] o_load_pc,
  output logic              o_flush,
  output logic [15:0]       o_mispredict_count,
  output logic              o_error
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;

  typedef enum logic {RUN, RECOVER} state_t;

  state_t            state, state_next;
  logic [PW-1:0]     head, tail, head_next, tail_next;
  logic [ADDR_W-1:0] pc_mem  [DEPTH];
  logic [ADDR_W-1:0] tgt_mem [DEPTH];
  logic [DEPTH-1:0]  pred_mem;
  logic [15:0]       mis_count;

  logic              empty;
  logic              push_req, pop_req, push, pop;
  logic              push_err, pop_err, mispredict;
  logic [ADDR_W-1:0] head_pc, head_tgt, actual_next;
  logic              head_pred;

  // Wrap bit distinguishes full from empty when the index bits match.
  assign full  = (head[IW-1:0] == tail[IW-1:0]) && (head[PW-1] != tail[PW-1]);
  assign empty = (head == tail);
  assign o_mispredict_count = mis_count;

  assign head_pc   = pc_mem[head[IW-1:0]];
  assign head_tgt  = tgt_mem[head[IW-1:0]];
  assign head_pred = pred_mem[head[IW-1:0]];

  always_comb begin
    push_req    = 1'b0;
    pop_req     = 1'b0;
    pop         = 1'b0;
    push        = 1'b0;
    push_err    = 1'b0;
    pop_err     = 1'b0;
    mispredict  = 1'b0;
    actual_next = ex_outcome ? ex_target : head_pc + ADDR_W'(4);
    head_next   = head;
    tail_next   = tail;
    state_next  = state;

    push_req = dec_valid && !stall && (state == RUN);
    pop_req  = ex_valid && !stall;
    pop      = pop_req && !empty && (state == RUN);
    mispredict = pop && ((ex_outcome != head_pred) ||
                         (ex_outcome && head_pred && (ex_target != head_tgt)));
    // A push coinciding with a mispredict is younger than the branch, so it is wrong-path.
    push     = push_req && (!full || pop) && !mispredict;
    push_err = push_req && full && !pop;
    pop_err  = pop_req && (empty || (state == RECOVER));

    if (!stall && (state == RECOVER))
      state_next = RUN;
    if (pop)
      head_next = head + PW'(1);
    if (mispredict) begin
      tail_next  = head + PW'(1);
      state_next = RECOVER;
    end else if (push) begin
      tail_next = tail + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail[IW-1:0]]   <= dec_pc;
      tgt_mem[tail[IW-1:0]]  <= dec_target;
      pred_mem[tail[IW-1:0]] <= dec_prediction | dec_is_jump;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_next;
      head  <= head_next;
      tail  <= tail_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_res_valid      <= 1'b0;
      o_res_pc         <= '0;
      o_res_target     <= '0;
      o_res_prediction <= 1'b0;
      o_res_outcome    <= 1'b0;
      o_load_we        <= 1'b0;
      o_load_pc        <= '0;
      o_flush          <= 1'b0;
      mis_count        <= '0;
      o_error          <= 1'b0;
    end else begin
      o_res_valid <= pop;
      o_load_we   <= mispredict;
      o_flush     <= mispredict;
      if (pop) begin
        o_res_pc         <= head_pc;
        o_res_target     <= actual_next;
        o_res_prediction <= head_pred;
        o_res_outcome    <= ex_outcome;
      end
      if (mispredict)
        o_load_pc <= actual_next;
      if (mispredict && (mis_count != 16'hFFFF))
        mis_count <= mis_count + 16'd1;
      if (push_err || pop_err)
        o_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_branch_resolver;

  localparam int ADDR_W = 26;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              stall = 1'b0;
  logic              dec_valid = 1'b0;
  logic [ADDR_W-1:0] dec_pc = '0;
  logic              dec_prediction = 1'b0;
  logic              dec_is_jump = 1'b0;
  logic [ADDR_W-1:0] dec_target = '0;
  logic              ex_valid = 1'b0;
  logic              ex_outcome = 1'b0;
  logic [ADDR_W-1:0] ex_target = '0;
  logic              full;
  logic              o_res_valid;
  logic [ADDR_W-1:0] o_res_pc;
  logic [ADDR_W-1:0] o_res_target;
  logic              o_res_prediction;
  logic              o_res_outcome;
  logic              o_load_we;
  logic [ADDR_W-1:0] o_load_pc;
  logic              o_flush;
  logic [15:0]       o_mispredict_count;
  logic              o_error;

  branch_resolver #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_prediction(dec_prediction),
    .dec_is_jump(dec_is_jump), .dec_target(dec_target),
    .ex_valid(ex_valid), .ex_outcome(ex_outcome), .ex_target(ex_target),
    .full(full), .o_res_valid(o_res_valid), .o_res_pc(o_res_pc),
    .o_res_target(o_res_target), .o_res_prediction(o_res_prediction),
    .o_res_outcome(o_res_outcome), .o_load_we(o_load_we), .o_load_pc(o_load_pc),
    .o_flush(o_flush), .o_mispredict_count(o_mispredict_count), .o_error(o_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic              pred;
    logic [ADDR_W-1:0] tgt;
  } entry_t;

  entry_t            mq[$];
  bit                m_recover;
  int                m_count;
  bit                m_error;
  bit                e_res_valid, e_res_pred, e_res_outcome, e_load_we, e_flush;
  logic [ADDR_W-1:0] e_res_pc, e_res_target, e_load_pc;
  int                tests_run = 0;
  int                tests_failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clearModel();
    mq.delete();
    m_recover = 0; m_count = 0; m_error = 0;
    e_res_valid = 0; e_res_pred = 0; e_res_outcome = 0; e_load_we = 0; e_flush = 0;
    e_res_pc = '0; e_res_target = '0; e_load_pc = '0;
  endtask

  task automatic checkAll(input string ctx);
    checkOutput({ctx, ".res_valid"}, o_res_valid, e_res_valid);
    checkOutput({ctx, ".load_we"}, o_load_we, e_load_we);
    checkOutput({ctx, ".flush"}, o_flush, e_flush);
    checkOutput({ctx, ".count"}, o_mispredict_count, m_count);
    checkOutput({ctx, ".error"}, o_error, m_error);
    checkOutput({ctx, ".full"}, full, mq.size() == DEPTH);
    checkOutput({ctx, ".res_pc"}, o_res_pc, e_res_pc);
    checkOutput({ctx, ".res_target"}, o_res_target, e_res_target);
    checkOutput({ctx, ".res_pred"}, o_res_prediction, e_res_pred);
    checkOutput({ctx, ".res_outcome"}, o_res_outcome, e_res_outcome);
    checkOutput({ctx, ".load_pc"}, o_load_pc, e_load_pc);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    dec_valid = 0; ex_valid = 0; stall = 0;
    clearModel();
    #1 checkAll("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: drive at negedge, advance the model at the edge, compare just after.
  task automatic applyStimulus(input string ctx, input bit dv, input logic [ADDR_W-1:0] pc,
                               input bit pred, input bit jmp, input logic [ADDR_W-1:0] tgt,
                               input bit ev, input bit outc, input logic [ADDR_W-1:0] etgt,
                               input bit stl);
    bit was_rec;
    bit mis;
    @(negedge clk);
    dec_valid = dv; dec_pc = pc; dec_prediction = pred; dec_is_jump = jmp; dec_target = tgt;
    ex_valid = ev; ex_outcome = outc; ex_target = etgt; stall = stl;
    @(posedge clk);
    e_res_valid = 0; e_load_we = 0; e_flush = 0;
    mis = 0;
    if (!stl) begin
      was_rec = m_recover;
      m_recover = 0;
      if (ev) begin
        if (was_rec || mq.size() == 0) begin
          m_error = 1;
        end else begin
          entry_t h = mq.pop_front();
          logic [ADDR_W-1:0] nxt = outc ? etgt : h.pc + ADDR_W'(4);
          mis = (outc != h.pred) || (outc && h.pred && etgt != h.tgt);
          e_res_valid = 1; e_res_pc = h.pc; e_res_target = nxt;
          e_res_pred = h.pred; e_res_outcome = outc;
          if (mis) begin
            e_load_we = 1; e_flush = 1; e_load_pc = nxt;
            if (m_count < 65535) m_count++;
            mq.delete();
            m_recover = 1;
          end
        end
      end
      if (dv && !was_rec && !mis) begin
        entry_t n;
        n.pc = pc; n.pred = pred | jmp; n.tgt = tgt;
        if (mq.size() < DEPTH) mq.push_back(n);
        else m_error = 1;
      end
    end
    #1 checkAll(ctx);
  endtask

  task automatic pushOp(input string ctx, input logic [ADDR_W-1:0] pc, input bit pred,
                        input bit jmp, input logic [ADDR_W-1:0] tgt);
    applyStimulus(ctx, 1, pc, pred, jmp, tgt, 0, 0, '0, 0);
  endtask

  task automatic popOp(input string ctx, input bit outc, input logic [ADDR_W-1:0] etgt);
    applyStimulus(ctx, 0, '0, 0, 0, '0, 1, outc, etgt, 0);
  endtask

  task automatic idleOp(input string ctx);
    applyStimulus(ctx, 0, '0, 0, 0, '0, 0, 0, '0, 0);
  endtask

  initial begin
    clearModel();
    doReset();
    idleOp("idle");

    // Correct not-taken, including the pc+4 modulo wrap
    pushOp("nt_push", 26'h100, 0, 0, 26'h180);
    popOp("nt_pop", 0, 26'h999);
    pushOp("wrap_push", 26'h3FFFFFC, 0, 0, 26'h10);
    popOp("wrap_pop", 0, 26'h0);

    // Direction mispredict, then a wrong-path push during RECOVER
    pushOp("dir_push", 26'h200, 1, 0, 26'h300);
    popOp("dir_pop", 0, 26'h300);
    pushOp("rec_push", 26'h500, 0, 0, 26'h600);
    idleOp("rec_after");
    popOp("rec_empty_pop", 0, 26'h0);
    doReset();

    // Target mispredict on a jump
    pushOp("jmp_push", 26'h40, 0, 1, 26'h80);
    popOp("jmp_pop", 1, 26'h90);
    idleOp("jmp_after");

    // Flush of younger entries
    pushOp("fl_push0", 26'h1000, 0, 0, 26'h0);
    pushOp("fl_push1", 26'h1004, 1, 0, 26'h2000);
    pushOp("fl_push2", 26'h1008, 0, 0, 26'h0);
    popOp("fl_pop_mis", 1, 26'h3000);
    idleOp("fl_idle");
    popOp("fl_pop_empty", 0, 26'h0);
    doReset();

    // Full and wrap with back-to-back push/pop pairs
    for (int i = 0; i < DEPTH; i++)
      pushOp("full_fill", 26'h4000 + 26'(i * 4), i[0], 0, 26'h8000 + 26'(i * 16));
    for (int i = 0; i < 10; i++) begin
      entry_t h = mq[0];
      applyStimulus("full_pair", 1, 26'h5000 + 26'(i * 4), i[1], 0, 26'h9000 + 26'(i * 16),
                    1, h.pred, h.tgt, 0);
    end
    pushOp("full_overflow", 26'h6000, 0, 0, 26'h0);
    doReset();

    // Stall freezes state: a stalled RECOVER remains RECOVER
    pushOp("st_push", 26'h700, 1, 0, 26'h740);
    applyStimulus("st_stalled_pop", 0, '0, 0, 0, '0, 1, 0, '0, 1);
    popOp("st_pop_mis", 0, 26'h0);
    applyStimulus("st_stall_rec", 1, 26'h800, 0, 0, '0, 0, 0, '0, 1);
    pushOp("st_rec_push", 26'h804, 0, 0, '0);
    idleOp("st_after");
    doReset();

    // Counter saturation
    @(negedge clk);
    force dut.mis_count = 16'hFFFE;
    @(negedge clk);
    release dut.mis_count;
    m_count = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      pushOp("sat_push", 26'hA00, 1, 0, 26'hB00);
      popOp("sat_pop", 0, 26'h0);
    end

    // Asynchronous reset while in RECOVER
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst.res_valid", o_res_valid, 0);
    checkOutput("mid_rst.load_we", o_load_we, 0);
    checkOutput("mid_rst.flush", o_flush, 0);
    checkOutput("mid_rst.count", o_mispredict_count, 0);
    checkOutput("mid_rst.load_pc", o_load_pc, 0);
    checkOutput("mid_rst.res_pc", o_res_pc, 0);
    doReset();
    pushOp("post_rst_push", 26'hC00, 0, 0, 26'h0);
    popOp("post_rst_pop", 0, 26'h0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bit dv = ($urandom_range(0, 99) < 55);
      bit ev = (mq.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
      bit stl = ($urandom_range(0, 99) < 10);
      bit pred = $urandom_range(0, 1);
      bit jmp = ($urandom_range(0, 99) < 20);
      logic [ADDR_W-1:0] pc = ($urandom_range(0, 99) < 5) ? 26'h3FFFFFC : ADDR_W'($urandom) & ~26'h3;
      logic [ADDR_W-1:0] tgt = ADDR_W'($urandom) & ~26'h3;
      bit outc = $urandom_range(0, 1);
      logic [ADDR_W-1:0] etgt = ADDR_W'($urandom) & ~26'h3;
      if (mq.size() > 0 && $urandom_range(0, 99) < 70) begin
        outc = mq[0].pred;
        etgt = mq[0].tgt;
      end
      applyStimulus("rand", dv, pc, pred, jmp, tgt, ev, outc, etgt, stl);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
